// File: rtl/prt_dptx_enc_pkg.sv
// prt_dptx_enc_pkg: shared constants for the DP TX 8b/10b encoder.
//   - C_SYM_W: width of one encoded line symbol
//   - 5b/6b and 3b/4b code tables in RD- form with their unbalanced flag
//   - valid K-code check and the line-order bit reversal helper
// Table literals are written in transmission order (abcdei / fghj, MSB = first bit).
package prt_dptx_enc_pkg;

  localparam int unsigned C_SYM_W  = 10;
  localparam logic [5:0]  C_K28_6B = 6'b001111;
  localparam logic [3:0]  C_A7_4B  = 4'b0111;

  // {unbalanced, abcdei} for D.x in RD- form
  function automatic logic [6:0] f_5b6b(input logic [4:0] x);
    case (x)
      5'd0:  return {1'b1, 6'b100111};
      5'd1:  return {1'b1, 6'b011101};
      5'd2:  return {1'b1, 6'b101101};
      5'd3:  return {1'b0, 6'b110001};
      5'd4:  return {1'b1, 6'b110101};
      5'd5:  return {1'b0, 6'b101001};
      5'd6:  return {1'b0, 6'b011001};
      5'd7:  return {1'b0, 6'b111000};
      5'd8:  return {1'b1, 6'b111001};
      5'd9:  return {1'b0, 6'b100101};
      5'd10: return {1'b0, 6'b010101};
      5'd11: return {1'b0, 6'b110100};
      5'd12: return {1'b0, 6'b001101};
      5'd13: return {1'b0, 6'b101100};
      5'd14: return {1'b0, 6'b011100};
      5'd15: return {1'b1, 6'b010111};
      5'd16: return {1'b1, 6'b011011};
      5'd17: return {1'b0, 6'b100011};
      5'd18: return {1'b0, 6'b010011};
      5'd19: return {1'b0, 6'b110010};
      5'd20: return {1'b0, 6'b001011};
      5'd21: return {1'b0, 6'b101010};
      5'd22: return {1'b0, 6'b011010};
      5'd23: return {1'b1, 6'b111010};
      5'd24: return {1'b1, 6'b110011};
      5'd25: return {1'b0, 6'b100110};
      5'd26: return {1'b0, 6'b010110};
      5'd27: return {1'b1, 6'b110110};
      5'd28: return {1'b0, 6'b001110};
      5'd29: return {1'b1, 6'b101110};
      5'd30: return {1'b1, 6'b011110};
      default: return {1'b1, 6'b101011};
    endcase
  endfunction

  // {unbalanced, fghj} for D.x.y in RD- form (primary .7)
  function automatic logic [4:0] f_3b4b(input logic [2:0] y);
    case (y)
      3'd0: return {1'b1, 4'b1011};
      3'd1: return {1'b0, 4'b1001};
      3'd2: return {1'b0, 4'b0101};
      3'd3: return {1'b0, 4'b1100};
      3'd4: return {1'b1, 4'b1101};
      3'd5: return {1'b0, 4'b1010};
      3'd6: return {1'b0, 4'b0110};
      default: return {1'b1, 4'b1110};
    endcase
  endfunction

  // {unbalanced, fghj} for K.x.y in RD- form; every K 4b code flips at RD+
  function automatic logic [4:0] f_k3b4b(input logic [2:0] y);
    case (y)
      3'd0: return {1'b1, 4'b1011};
      3'd1: return {1'b0, 4'b0110};
      3'd2: return {1'b0, 4'b1010};
      3'd3: return {1'b0, 4'b1100};
      3'd4: return {1'b1, 4'b1101};
      3'd5: return {1'b0, 4'b0101};
      3'd6: return {1'b0, 4'b1001};
      default: return {1'b1, 4'b0111};
    endcase
  endfunction

  // K28.0-7, K23.7, K27.7, K29.7, K30.7
  function automatic logic f_k_valid(input logic [7:0] dat);
    return (dat[4:0] == 5'd28) ||
           ((dat[7:5] == 3'd7) && ((dat[4:0] == 5'd23) || (dat[4:0] == 5'd27) ||
                                   (dat[4:0] == 5'd29) || (dat[4:0] == 5'd30)));
  endfunction

  // Table order (a at MSB) to bus order (a at bit 0)
  function automatic logic [C_SYM_W-1:0] f_rev10(input logic [C_SYM_W-1:0] v);
    logic [C_SYM_W-1:0] r;
    for (int unsigned n = 0; n < C_SYM_W; n++) r[n] = v[C_SYM_W-1-n];
    return r;
  endfunction

endpackage

// File: rtl/prt_dptx_enc_if.sv
// prt_dp_tx_lnk_if: per-lane, per-symbol link bus into the 8b/10b encoder.
//   disp_ctl/disp_val/k : [lane][symbol] flags
//   dat                 : [lane][symbol] 8-bit symbol value (HGFEDCBA)
//   src modport drives the bus, snk modport consumes it.
interface prt_dp_tx_lnk_if #(
  parameter int unsigned P_LANES = 2,
  parameter int unsigned P_SPL   = 2
);
  logic [P_LANES-1:0][P_SPL-1:0]      disp_ctl;
  logic [P_LANES-1:0][P_SPL-1:0]      disp_val;
  logic [P_LANES-1:0][P_SPL-1:0]      k;
  logic [P_LANES-1:0][P_SPL-1:0][7:0] dat;

  modport src (output disp_ctl, disp_val, k, dat);
  modport snk (input  disp_ctl, disp_val, k, dat);
endinterface

// File: rtl/prt_dptx_enc_sym.sv
// prt_dptx_enc_sym: combinational single-symbol 8b/10b encoder.
//   i_rd_in  : running disparity before this symbol (0 = RD-, 1 = RD+)
//   i_k      : control symbol request
//   i_dat    : symbol value HGFEDCBA
//   o_code   : 10-bit code, bit 0 = 'a' (first on the line)
//   o_rd_out : running disparity after this symbol
//   o_kerr   : i_k set with a value that is not a valid K code (encoded as data)
module prt_dptx_enc_sym
  import prt_dptx_enc_pkg::*;
(
  input  logic               i_rd_in,
  input  logic               i_k,
  input  logic [7:0]         i_dat,
  output logic [C_SYM_W-1:0] o_code,
  output logic               o_rd_out,
  output logic               o_kerr
);

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_kvalid, w_kuse, w_u6, w_u4, w_rd_mid, w_a7, w_inv6, w_inv4;
  logic [5:0] w_c6;
  logic [3:0] w_c4;

  always_comb begin
    w_x      = i_dat[4:0];
    w_y      = i_dat[7:5];
    w_kvalid = f_k_valid(i_dat);
    w_kuse   = i_k & w_kvalid;

    if (w_kuse && (w_x == 5'd28)) {w_u6, w_c6} = {1'b1, C_K28_6B};
    else                          {w_u6, w_c6} = f_5b6b(w_x);
    // D.7 is balanced but still has distinct RD-/RD+ forms
    w_inv6   = i_rd_in & (w_u6 | (w_x == 5'd7));
    w_rd_mid = i_rd_in ^ w_u6;

    // Alternate .7 avoids a run of five equal bits across the 6b/4b seam
    w_a7 = (w_y == 3'd7) &&
           (w_rd_mid ? ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))
                     : ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20)));

    if (w_kuse) begin
      {w_u4, w_c4} = f_k3b4b(w_y);
      w_inv4       = w_rd_mid;
    end else if (w_a7) begin
      {w_u4, w_c4} = {1'b1, C_A7_4B};
      w_inv4       = w_rd_mid;
    end else begin
      {w_u4, w_c4} = f_3b4b(w_y);
      // D.x.3 is balanced but still has distinct RD-/RD+ forms
      w_inv4       = w_rd_mid & (w_u4 | (w_y == 3'd3));
    end

    o_code   = f_rev10({(w_inv6 ? ~w_c6 : w_c6), (w_inv4 ? ~w_c4 : w_c4)});
    o_rd_out = w_rd_mid ^ w_u4;
    o_kerr   = i_k & ~w_kvalid;
  end

endmodule

// File: rtl/prt_dptx_enc.sv
// prt_dptx_enc: DP TX 8b/10b encoder stage, one running disparity per lane.
//   RST_IN       : async active-high reset (outputs 0, all RD = RD-)
//   CLK_IN       : clock
//   CTL_LANES_IN : 0 = 2 active lanes, 1 = 4 active lanes
//   LNK_SNK_IF   : link bus (disp_ctl/disp_val/k/dat per lane, per symbol)
//   PHY_DAT_OUT  : lane i symbol j at [(i*P_SPL+j)*10 +: 10], symbol 0 sent first
//   STA_KERR_OUT : per-lane pulse, invalid K code seen in that output cycle
// Latency is two clocks: input register, then encode + output register.
module prt_dptx_enc
  import prt_dptx_enc_pkg::*;
#(
  parameter int unsigned P_LANES = 2,
  parameter int unsigned P_SPL   = 2
)(
  input  logic                               RST_IN,
  input  logic                               CLK_IN,
  input  logic                               CTL_LANES_IN,
  prt_dp_tx_lnk_if.snk                       LNK_SNK_IF,
  output logic [P_LANES*P_SPL*C_SYM_W-1:0]   PHY_DAT_OUT,
  output logic [P_LANES-1:0]                 STA_KERR_OUT
);

  localparam int unsigned C_LANE_W = P_SPL * C_SYM_W;

  logic                                 r_lanes;
  logic [P_LANES-1:0][P_SPL-1:0]        r_disp_ctl, r_disp_val, r_k;
  logic [P_LANES-1:0][P_SPL-1:0][7:0]   r_dat;
  logic [P_LANES-1:0]                   r_rd;

  logic [P_LANES-1:0][C_LANE_W-1:0]     w_lane_code;
  logic [P_LANES-1:0]                   w_lane_rd, w_lane_kerr, w_lane_en;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_lanes    <= 1'b0;
      r_disp_ctl <= '0;
      r_disp_val <= '0;
      r_k        <= '0;
      r_dat      <= '0;
    end else begin
      r_lanes    <= CTL_LANES_IN;
      r_disp_ctl <= LNK_SNK_IF.disp_ctl;
      r_disp_val <= LNK_SNK_IF.disp_val;
      r_k        <= LNK_SNK_IF.k;
      r_dat      <= LNK_SNK_IF.dat;
    end
  end

  // RD chains through the symbols of a lane in transmission order; a forced
  // disparity replaces the chained value for that symbol only.
  for (genvar i = 0; i < P_LANES; i++) begin : g_lane
    logic [P_SPL:0]   w_rd;
    logic [P_SPL-1:0] w_kerr;

    assign w_rd[0] = r_rd[i];

    for (genvar j = 0; j < P_SPL; j++) begin : g_sym
      logic w_rd_sel;
      assign w_rd_sel = r_disp_ctl[i][j] ? r_disp_val[i][j] : w_rd[j];

      prt_dptx_enc_sym u_sym (
        .i_rd_in  (w_rd_sel),
        .i_k      (r_k[i][j]),
        .i_dat    (r_dat[i][j]),
        .o_code   (w_lane_code[i][j*C_SYM_W +: C_SYM_W]),
        .o_rd_out (w_rd[j+1]),
        .o_kerr   (w_kerr[j])
      );
    end

    assign w_lane_rd[i]   = w_rd[P_SPL];
    assign w_lane_kerr[i] = |w_kerr;
  end

  // Lanes 0-1 are always active; lanes 2-3 follow the registered lane count.
  always_comb begin
    w_lane_en = '0;
    for (int unsigned i = 0; i < P_LANES; i++) w_lane_en[i] = (i < 2) || r_lanes;
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      PHY_DAT_OUT  <= '0;
      STA_KERR_OUT <= '0;
      r_rd         <= '0;
    end else begin
      for (int unsigned i = 0; i < P_LANES; i++) begin
        if (w_lane_en[i]) begin
          PHY_DAT_OUT[i*C_LANE_W +: C_LANE_W] <= w_lane_code[i];
          STA_KERR_OUT[i]                     <= w_lane_kerr[i];
          r_rd[i]                             <= w_lane_rd[i];
        end else begin
          PHY_DAT_OUT[i*C_LANE_W +: C_LANE_W] <= '0;
          STA_KERR_OUT[i]                     <= 1'b0;
          r_rd[i]                             <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prt_dptx_enc.sv
// tb_prt_dptx_enc: directed self-checking bench for prt_dptx_enc (4 lanes, 2 symbols/lane).
// Expected codes are hand-written in abcdeifghj order and bit-reversed for the bus.
module tb_prt_dptx_enc;

  localparam int unsigned NL = 4;
  localparam int unsigned NS = 2;

  localparam logic [9:0] E_D00_N  = 10'b1001110100; // D0.0  RD-
  localparam logic [9:0] E_D00_P  = 10'b0110001011; // D0.0  RD+
  localparam logic [9:0] E_D215   = 10'b1010101010; // D21.5 either RD
  localparam logic [9:0] E_K285_N = 10'b0011111010; // K28.5 RD-
  localparam logic [9:0] E_K285_P = 10'b1100000101; // K28.5 RD+
  localparam logic [9:0] E_D177_N = 10'b1000110111; // D17.7 RD- (A7)
  localparam logic [9:0] E_D177_P = 10'b1000110001; // D17.7 RD+ (P7)
  localparam logic [9:0] E_D117_P = 10'b1101001000; // D11.7 RD+ (A7)

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  ctl = 1'b1;
  logic [NL*NS*10-1:0]   phy;
  logic [NL-1:0]         kerr;
  int                    n_vec = 0;
  int                    n_err = 0;

  prt_dp_tx_lnk_if #(.P_LANES(NL), .P_SPL(NS)) lnk_if ();

  prt_dptx_enc #(.P_LANES(NL), .P_SPL(NS)) dut (
    .RST_IN       (rst),
    .CLK_IN       (clk),
    .CTL_LANES_IN (ctl),
    .LNK_SNK_IF   (lnk_if),
    .PHY_DAT_OUT  (phy),
    .STA_KERR_OUT (kerr)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int n = 0; n < 10; n++) r[n] = v[9-n];
    return r;
  endfunction

  // Returned in abcdeifghj order so it reads like the expected literals
  function automatic logic [9:0] code(input int l, input int s);
    return rev10(phy[(l*NS+s)*10 +: 10]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sym(input int l, input int s, input logic dc, input logic dv,
                         input logic k, input logic [7:0] d);
    lnk_if.disp_ctl[l][s] = dc;
    lnk_if.disp_val[l][s] = dv;
    lnk_if.k[l][s]        = k;
    lnk_if.dat[l][s]      = d;
  endtask

  task automatic set_all(input logic k0, input logic [7:0] d0, input logic k1, input logic [7:0] d1);
    for (int l = 0; l < NL; l++) begin
      set_sym(l, 0, 1'b0, 1'b0, k0, d0);
      set_sym(l, 1, 1'b0, 1'b0, k1, d1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctl = 1'b1;
    set_all(1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    n_vec++; if (phy !== '0) begin n_err++; $display("FAIL reset_phy got %h exp 0", phy); end
    n_vec++; if (kerr !== '0) begin n_err++; $display("FAIL reset_kerr got %b exp 0", kerr); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_d00_latency();
    apply_reset();
    set_all(1'b0, 8'hB5, 1'b0, 8'hB5);
    tick(); tick(); tick();
    n_vec++; if (code(0, 0) !== E_D215) begin n_err++; $display("FAIL d215_s0 got %b exp %b", code(0, 0), E_D215); end
    set_all(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    n_vec++; if (code(0, 1) !== E_D215) begin n_err++; $display("FAIL d00_lat1 got %b exp %b", code(0, 1), E_D215); end
    tick();
    n_vec++; if (code(0, 0) !== E_D00_N) begin n_err++; $display("FAIL d00_s0 got %b exp %b", code(0, 0), E_D00_N); end
    n_vec++; if (code(0, 1) !== E_D00_N) begin n_err++; $display("FAIL d00_s1 got %b exp %b", code(0, 1), E_D00_N); end
    tick();
    n_vec++; if (code(0, 0) !== E_D00_N) begin n_err++; $display("FAIL d00_s0_c2 got %b exp %b", code(0, 0), E_D00_N); end
    n_vec++; if (kerr !== 4'b0000) begin n_err++; $display("FAIL d00_kerr got %b exp 0000", kerr); end
  endtask

  task automatic test_k285_stream();
    apply_reset();
    set_all(1'b0, 8'hB5, 1'b0, 8'hB5);
    tick(); tick();
    n_vec++; if (code(1, 1) !== E_D215) begin n_err++; $display("FAIL k_pre_d215 got %b exp %b", code(1, 1), E_D215); end
    set_all(1'b1, 8'hBC, 1'b1, 8'hBC);
    tick(); tick();
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (code(0, 0) !== E_K285_N) begin n_err++; $display("FAIL k285_s0_c%0d got %b exp %b", c, code(0, 0), E_K285_N); end
      n_vec++; if (code(0, 1) !== E_K285_P) begin n_err++; $display("FAIL k285_s1_c%0d got %b exp %b", c, code(0, 1), E_K285_P); end
      tick();
    end
    n_vec++; if (kerr !== 4'b0000) begin n_err++; $display("FAIL k285_kerr got %b exp 0000", kerr); end
  endtask

  task automatic test_force();
    apply_reset();
    set_all(1'b1, 8'hBC, 1'b1, 8'hBC);
    for (int l = 0; l < NL; l++) set_sym(l, 0, 1'b1, 1'b1, 1'b1, 8'hBC);
    tick(); tick();
    n_vec++; if (code(0, 0) !== E_K285_P) begin n_err++; $display("FAIL force_s0 got %b exp %b", code(0, 0), E_K285_P); end
    n_vec++; if (code(0, 1) !== E_K285_N) begin n_err++; $display("FAIL force_s1 got %b exp %b", code(0, 1), E_K285_N); end
  endtask

  task automatic test_alt7_kerr();
    apply_reset();
    set_all(1'b0, 8'hF1, 1'b0, 8'hEB);
    tick();
    set_all(1'b0, 8'h00, 1'b0, 8'h00);
    set_sym(0, 0, 1'b0, 1'b0, 1'b1, 8'h00);
    set_sym(2, 0, 1'b0, 1'b0, 1'b1, 8'h00);
    set_sym(2, 1, 1'b0, 1'b0, 1'b1, 8'h1D);
    tick();
    n_vec++; if (code(0, 0) !== E_D177_N) begin n_err++; $display("FAIL d177_n got %b exp %b", code(0, 0), E_D177_N); end
    n_vec++; if (code(0, 1) !== E_D117_P) begin n_err++; $display("FAIL d117_p got %b exp %b", code(0, 1), E_D117_P); end
    n_vec++; if (kerr !== 4'b0000) begin n_err++; $display("FAIL alt7_kerr got %b exp 0000", kerr); end
    set_all(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    n_vec++; if (code(0, 0) !== E_D00_N) begin n_err++; $display("FAIL kerr_code got %b exp %b", code(0, 0), E_D00_N); end
    n_vec++; if (kerr !== 4'b0101) begin n_err++; $display("FAIL kerr_pulse got %b exp 0101", kerr); end
    tick();
    n_vec++; if (kerr !== 4'b0000) begin n_err++; $display("FAIL kerr_clear got %b exp 0000", kerr); end
  endtask

  task automatic test_lane_disable();
    ctl = 1'b1;
    apply_reset();
    set_all(1'b0, 8'hB5, 1'b0, 8'hF1);
    tick();
    set_all(1'b0, 8'hB5, 1'b0, 8'hB5);
    tick(); tick();
    n_vec++; if (code(2, 0) !== E_D215) begin n_err++; $display("FAIL ld_pre got %b exp %b", code(2, 0), E_D215); end
    ctl = 1'b0;
    set_sym(0, 0, 1'b0, 1'b0, 1'b1, 8'h00);
    set_sym(3, 0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    n_vec++; if (code(2, 0) !== E_D215) begin n_err++; $display("FAIL ld_lat1 got %b exp %b", code(2, 0), E_D215); end
    tick();
    n_vec++; if (phy[79:40] !== 40'h0) begin n_err++; $display("FAIL ld_off got %h exp 0", phy[79:40]); end
    n_vec++; if (kerr !== 4'b0001) begin n_err++; $display("FAIL ld_kerr got %b exp 0001", kerr); end
    n_vec++; if (code(0, 0) !== E_D00_P) begin n_err++; $display("FAIL ld_d00_p got %b exp %b", code(0, 0), E_D00_P); end
    ctl = 1'b1;
    set_all(1'b0, 8'hF1, 1'b0, 8'hB5);
    tick(); tick();
    n_vec++; if (code(2, 0) !== E_D177_N) begin n_err++; $display("FAIL ld_resume got %b exp %b", code(2, 0), E_D177_N); end
    n_vec++; if (code(0, 0) !== E_D177_P) begin n_err++; $display("FAIL ld_lane0_p got %b exp %b", code(0, 0), E_D177_P); end
  endtask

  task automatic test_async_reset();
    ctl = 1'b1;
    apply_reset();
    set_all(1'b1, 8'hBC, 1'b1, 8'hBC);
    tick(); tick();
    n_vec++; if (code(3, 0) !== E_K285_N) begin n_err++; $display("FAIL ar_pre got %b exp %b", code(3, 0), E_K285_N); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (phy !== '0) begin n_err++; $display("FAIL ar_phy got %h exp 0", phy); end
    n_vec++; if (kerr !== '0) begin n_err++; $display("FAIL ar_kerr got %b exp 0", kerr); end
    #1 rst = 1'b0;
    tick();
    n_vec++; if (code(0, 0) !== E_D00_N) begin n_err++; $display("FAIL ar_stage1 got %b exp %b", code(0, 0), E_D00_N); end
    tick();
    n_vec++; if (code(0, 0) !== E_K285_N) begin n_err++; $display("FAIL ar_k285_s0 got %b exp %b", code(0, 0), E_K285_N); end
    n_vec++; if (code(0, 1) !== E_K285_P) begin n_err++; $display("FAIL ar_k285_s1 got %b exp %b", code(0, 1), E_K285_P); end
  endtask

  initial begin
    test_reset();
    test_d00_latency();
    test_k285_stream();
    test_force();
    test_alt7_kerr();
    test_lane_disable();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prt_dptx_enc.md
Name: prt_dptx_enc

Overview:
- 8b/10b encoder stage directly downstream of the DP TX training/main-link mux.
- Consumes per-lane, per-symbol {disp_ctl, disp_val, k, dat} from the link interface and produces 10-bit line codes for the PHY.
- Keeps one running disparity (RD) per lane and honours forced-disparity requests from training.

Parameters:
- P_LANES, 2, number of lanes (2 or 4)
- P_SPL, 2, symbols per lane per clock (2 or 4)

Ports:
- RST_IN  input  1  reset, asynchronous, active-high
- CLK_IN  input  1  clock
- CTL_LANES_IN  input  1  active lanes: 0 = 2 lanes, 1 = 4 lanes
- LNK_SNK_IF  prt_dp_tx_lnk_if.snk  interface  disp_ctl/disp_val/k [P_SPL] and dat [P_SPL][8] per lane
- PHY_DAT_OUT  output  P_LANES*P_SPL*10  encoded symbols; lane i, symbol j at [(i*P_SPL+j)*10 +: 10]; bit 0 = code bit 'a' (first on line), bit 9 = 'j'
- STA_KERR_OUT  output  P_LANES  per-lane pulse: invalid K code seen in that cycle

Behaviour:
- Reset:
  - Async reset forces PHY_DAT_OUT = 0, STA_KERR_OUT = 0, all RD = negative (RD-).
  - Assertion mid-stream takes effect immediately.
  - First symbol after release encodes with RD-.
- Pipeline:
  - Stage 1 registers CTL_LANES_IN and all link inputs.
  - Stage 2 encodes and registers PHY_DAT_OUT, STA_KERR_OUT and RD.
  - Fixed latency 2 clocks from link input to PHY_DAT_OUT. No stalls, no valid; every cycle is a symbol cycle.
- Symbol order: within a cycle, symbol 0 is transmitted first. RD chains combinationally 0 → P_SPL-1. Stored RD = RD after the last symbol.
- Per-symbol RD selection:
  - if disp_ctl[j]=1, RD_in = disp_val[j] (0 = RD-, 1 = RD+); else RD_in = RD out of the previous symbol.
  - Forcing overrides the chained value for that symbol only; later symbols chain from its result.
- Encoding: standard Widmer-Franaszek 5b/6b + 3b/4b (EDCBA → abcdei, HGF → fghj).
  - Alternate A7 (0111/1000) is used for D.x.7 when (RD- and x ∈ {17,18,20}) or (RD+ and x ∈ {11,13,14}).
  - RD_out is inverted when the 10-bit code is unbalanced, else RD_out = RD_in.
- Valid K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7 (dat = 0x1C,3C,5C,7C,9C,BC,DC,FC,F7,FB,FD,FE).
  - k=1 with any other dat: encoded as data D(dat), STA_KERR_OUT[lane] = 1 for that output cycle.
  - Multiple bad symbols in one lane give one pulse.
- Lane disable: if P_LANES=4 and registered CTL_LANES_IN=0:
  - lanes 2–3 output 0, STA_KERR_OUT = 0, and RD held at RD-;
  - on re-enable, encoding resumes from RD-.
- Lanes are fully independent; no cross-lane state.

Decomposition:
- Package prt_dptx_enc_pkg:
  - 5b/6b and 3b/4b code constants (RD- form + unbalanced flag);
  - valid-K list;
  - symbol-width constant 10.
- Sub-module prt_dptx_enc_sym: purely combinational single-symbol encoder, inputs (rd_in, k, dat[7:0]), outputs (code[9:0], rd_out, kerr).
  - Instantiated P_LANES*P_SPL times; chained per lane in generate loops in prt_dptx_enc.
  - Independently unit-testable against the full 512-entry table.

Test Plan:
- Reset, then lane 0 all symbols D0.0 (0x00, k=0, disp_ctl=0) → every code = 1001110100 (abcdeifghj) and RD stays RD-; appears on PHY_DAT_OUT exactly 2 clocks after input.
- Continuous K28.5 (0xBC, k=1), P_SPL=2 → symbols alternate 0011111010, 1100000101 within and across cycles, no glitch at cycle boundaries.
- D21.5 (0xB5) stream from reset → 1010101010 each symbol, RD unchanged; then K28.5 → 0011111010.
- Force: disp_ctl=1, disp_val=1 on symbol 0 with K28.5 while RD = RD- → symbol 0 = 1100000101, symbol 1 (K28.5, disp_ctl=0) = 0011111010.
- D17.7 (0xF1) at RD- → 1000110111, RD becomes RD+; D11.7 (0xEB) then at RD+ → 1101001000 (A7); k=1 with dat=0x00 → code for D0.0 and one-cycle STA_KERR_OUT pulse on that lane only.
- P_LANES=4: CTL_LANES_IN toggled 1→0 → lanes 2–3 output 0 from 2 clocks later; async reset asserted mid-stream → outputs 0 in the same cycle, first post-reset K28.5 = 0011111010.
